// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // Stream framing: 16-bit word-count header, then 4 bytes per word.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // True in the states that accept bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream into 32-bit big-endian words; the first byte lands in [31:24].
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0]           r_word;
    logic [BYTE_CNT_W-1:0] r_cnt;

    // Shift register and byte counter; a start clears any stale partial word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (shift_en) begin
            r_word <= {r_word[23:0], byte_in};
            r_cnt  <= r_cnt + BYTE_CNT_W'(1);
        end
    end

    // The accepted byte completes the word; the counter wraps back to 0 by itself.
    assign word_full = shift_en && (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it into instruction
// memory word by word from address 0, and releases the core only after a full load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

    state_t            r_state;
    logic [7:0]        r_hdr_hi;
    logic [15:0]       r_last_idx;
    logic [IDX_W-1:0]  r_word_idx;
    logic              r_byte_ready;
    logic              r_imem_we;
    logic              r_core_reset_n;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    state_t            w_next;
    logic              w_xfer;
    logic              w_start_go;
    logic              w_shift;
    logic [15:0]       w_hdr_n;
    logic              w_last_word;
    logic              w_word_full;
    logic [31:0]       w_word;
    logic              w_byte_ready_nx;
    logic              w_imem_we_nx;
    logic              w_core_reset_n_nx;
    logic              w_busy_nx;
    logic              w_done_nx;
    logic              w_error_nx;

    // A byte moves only when the registered ready is high, so ready=0 masks valid.
    assign w_xfer      = byte_valid & r_byte_ready;
    assign w_start_go  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_shift     = w_xfer && (r_state == DATA);
    assign w_hdr_n     = {r_hdr_hi, byte_data};
    assign w_last_word = (16'(r_word_idx) == r_last_idx);

    word_packer u_packer (
        .clock     (clock),
        .reset_n   (reset_n),
        .shift_en  (w_shift),
        .clear     (w_start_go),
        .byte_in   (byte_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // Next-state logic plus next values of the registered control outputs.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = HDR_HI;
            HDR_HI:  if (w_xfer) w_next = HDR_LO;
            HDR_LO: begin
                if (w_xfer) begin
                    // 16-bit compare so a non-zero high byte can never alias a legal count.
                    if ((w_hdr_n == 16'd0) || (w_hdr_n > DEPTH_16)) w_next = ERROR;
                    else                                            w_next = DATA;
                end
            end
            DATA:    if (w_word_full) w_next = WRITE;
            WRITE:   w_next = w_last_word ? DONE : DATA;
            DONE:    if (start) w_next = HDR_HI;
            ERROR:   if (start) w_next = HDR_HI;
            default: w_next = IDLE;
        endcase

        w_byte_ready_nx   = accepts_bytes(w_next);
        w_busy_nx         = accepts_bytes(w_next) || (w_next == WRITE);
        w_imem_we_nx      = (w_next == WRITE);
        w_done_nx         = (w_next == DONE);
        w_error_nx        = (w_next == ERROR);
        w_core_reset_n_nx = (w_next == DONE);
    end

    // State register and registered outputs, all decoded from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_byte_ready   <= 1'b0;
            r_imem_we      <= 1'b0;
            r_core_reset_n <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_byte_ready   <= w_byte_ready_nx;
            r_imem_we      <= w_imem_we_nx;
            r_core_reset_n <= w_core_reset_n_nx;
            r_busy         <= w_busy_nx;
            r_done         <= w_done_nx;
            r_error        <= w_error_nx;
        end
    end

    // Header capture; the last word index is kept instead of N to simplify the end test.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr_hi   <= '0;
            r_last_idx <= '0;
        end else begin
            if (w_xfer && (r_state == HDR_HI)) r_hdr_hi <= byte_data;
            if (w_xfer && (r_state == HDR_LO)) r_last_idx <= w_hdr_n - 16'd1;
        end
    end

    // Word index: restarts on each load, advances after every non-final write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_word_idx <= '0;
        end else if (w_start_go) begin
            r_word_idx <= '0;
        end else if ((r_state == WRITE) && !w_last_word) begin
            r_word_idx <= r_word_idx + IDX_W'(1);
        end
    end

    assign byte_ready   = r_byte_ready;
    assign imem_we      = r_imem_we;
    assign imem_addr    = ADDR_W'({r_word_idx, 2'b00});
    assign imem_wdata   = w_word;
    assign core_reset_n = r_core_reset_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer for the instruction memory. At boot it receives a program as a byte stream over a valid/ready handshake.
- It packs the bytes into 32-bit big-endian words and writes them sequentially into instruction memory from word 0.
- It holds the MIPS core in reset until the load completes.
- Sits between an external byte source (UART/JTAG bridge) and the instruction memory write port; drives the core's reset input.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory; maximum loadable program length.
- ADDR_W, 32, width of imem_addr (byte address, PC-compatible).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a new load.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  byte address of the word written; always word-aligned (bits [1:0] = 0).
- imem_wdata  out  32  word written.
- core_reset_n  out  1  active-low reset to the MIPS core.
- busy  out  1  load in progress.
- done  out  1  load completed successfully (level).
- error  out  1  header rejected (level).

Behaviour:
- Reset: state IDLE. All outputs 0, including core_reset_n = 0; word index and byte counter cleared.
- Transfer occurs only on a cycle with byte_valid & byte_ready. byte_valid is ignored when byte_ready = 0.
- Stream format: 2-byte header giving word count N (MSB first), then 4·N data bytes. The first byte of each word maps to [31:24].
- All outputs are registered.
- States and transitions:
  - IDLE: byte_ready = 0. start -> HDR_HI.
  - HDR_HI: byte_ready = 1, busy = 1. On transfer, latch N[15:8] -> HDR_LO.
  - HDR_LO: byte_ready = 1, busy = 1. On transfer, latch N[7:0]. If N == 0 or N > DEPTH -> ERROR; else -> DATA.
  - DATA: byte_ready = 1, busy = 1. Shift each accepted byte into the packer. On the 4th byte -> WRITE.
  - WRITE: byte_ready = 0. For exactly one cycle, imem_we = 1, imem_addr = word_idx << 2, imem_wdata = packed word. If word_idx == N-1 -> DONE; else word_idx++ and -> DATA.
  - DONE: done = 1, core_reset_n = 1, busy = 0. start -> HDR_HI (clears done, reasserts core reset).
  - ERROR: error = 1, core_reset_n = 0. start -> HDR_HI (clears error).
- start is ignored in HDR_HI, HDR_LO, DATA and WRITE.
- Latency:
  - 4th byte of a word accepted at cycle t -> imem_we high at cycle t+1.
  - Last write at cycle t -> done and core_reset_n high at cycle t+1.
- Throughput: at most 4 bytes per 5 cycles; byte_ready drops during WRITE.
- core_reset_n is 0 in every state except DONE. The core never runs on a partially loaded program.
- Stalls: byte_valid low for any number of cycles holds state and partial word unchanged.
- Boundaries:
  - N == DEPTH is legal and writes words 0..DEPTH-1.
  - N == DEPTH+1 -> ERROR.
  - word_idx never exceeds DEPTH-1.
- Reset mid-load: immediate return to IDLE with all outputs 0. Already-written memory words are not cleared.
- Width: the header is 16 bits and the comparison against DEPTH uses 16 bits. word_idx is $clog2(DEPTH) bits, zero-extended into imem_addr.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR).
  - HDR_BYTES = 2, BYTES_PER_WORD = 4.
- Sub-module word_packer:
  - 8-to-32 big-endian shift register with 2-bit byte counter.
  - Inputs: shift_en, clear.
  - Outputs: word, word_full.
- FSM, address counter and header comparison stay in imem_loader.

Test Plan:
- Reset, then no start -> all outputs 0, byte_ready 0 indefinitely.
- start; stream 00 02 DE AD BE EF 01 23 45 67 with valid always high:
  - two writes: addr 0x0 data 0xDEADBEEF, then addr 0x4 data 0x01234567.
  - byte_ready low in each WRITE cycle.
  - done = 1 and core_reset_n = 1 one cycle after the 2nd write.
- Same stream with byte_valid toggled randomly and gaps of 0–7 cycles -> identical writes and order; no duplicate or lost bytes.
- Header 00 00 -> ERROR: error = 1, no imem_we, core_reset_n = 0. Header 00 41 with DEPTH = 64 -> ERROR. Header 00 40 -> 64 writes, last at addr 0xFC.
- Assert reset_n low after 2 of 4 bytes of word 1:
  - outputs 0 immediately.
  - new start plus full stream loads correctly from word 0.
- start pulses during DATA -> ignored. start in DONE -> done clears, core_reset_n = 0, and a new load proceeds.
